isb_prefetcher: RTL and testbench
=================================

Name: isb_prefetcher

Overview:
Irregular Stream Buffer (ISB) temporal prefetcher that sits beside the L2/LLC request path.
- Observes (pc, addr) accesses and trains per-PC address correlations into a linear "structural" address space.
- On each access, predicts the next DEGREE structural successors and emits them as prefetch candidates one cycle later.
- Accepts one access per cycle; it never stalls.

Parameters:
- DEGREE, 1, number of structural successors predicted per access (legal 1..4).
- TU_ENTRIES, 16, training-unit entries; direct-mapped, index pc[3:0].
- PS_ENTRIES, 64, physical-to-structural map entries; direct-mapped, index addr[5:0].
- SP_ENTRIES, 64, structural-to-physical map entries; direct-mapped, index str[5:0].
- CHUNK, 16, structural addresses reserved per newly allocated stream (power of 2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- v_in  in  1  access valid
- pc_in  in  16  PC of the access
- addr_in  in  16  block address of the access
- pf_valid  out  DEGREE  bit k set = pf_addr slot k is valid
- pf_addr  out  16*DEGREE  slot k = bits [16k+15:16k], k-th successor

Behaviour:
- Reset: synchronous, active-high.
  - Clears all valid bits in TU/PS/SP and sets the allocation pointer alloc_ptr=0.
  - pf_valid=0, pf_addr=0.
  - Reset mid-operation discards any in-flight access; outputs are 0 on the next cycle.
- Table entries:
  - TU entry: valid, pc tag (16 bits), last_addr (16 bits).
  - PS entry: valid, addr tag (16 bits), str (16 bits), conf (2 bits).
  - SP entry: valid, str tag (16 bits), addr (16 bits).
  - Lookups are combinational; writes occur at posedge. A conflicting index silently overwrites the old entry.
- Prediction uses table state before this cycle's writes.
  - If PS hits on B=addr_in with str s: for k=0..DEGREE-1, read SP[s+1+k]. pf_valid[k]=SP hit, pf_addr slot k=SP addr.
  - Otherwise all pf_valid bits are 0.
  - Outputs are registered: latency 1 cycle. pf_valid=0 on any cycle after v_in=0.
- Training (when v_in=1):
  - TU miss: install {pc_in, last_addr=B}. No correlation is trained.
  - TU hit with last_addr A==B: no correlation is trained.
  - TU hit with A!=B:
    - If PS misses on A: s_A=alloc_ptr. Write PS[A]={s_A, conf 0} and SP[s_A]=A. alloc_ptr+=CHUNK (16-bit wrap).
    - If s_A is the last slot of its chunk ((s_A mod CHUNK)==CHUNK-1): B is not assigned.
    - Else, with t=s_A+1:
      - PS miss on B: write PS[B]={t, conf 0}, SP[t]=B.
      - PS hit with str==t: conf saturating increment (max 3).
      - PS hit with str!=t and conf>0: conf decrement only.
      - PS hit with str!=t and conf==0: write PS[B]={t, conf 0}, SP[t]=B.
  - TU last_addr is then set to B.
- When the same entry is read and written in one cycle, reads see old data and the write lands at posedge. Back-to-back accesses see all prior writes.

Decomposition:
- Package isb_pkg: ADDR_W=16, STR_W=16, CONF_W=2, CONF_MAX=3, and packed structs tu_entry_t, ps_entry_t, sp_entry_t.
- One reusable sub-module, isb_dm_table: a parameterised direct-mapped tagged table with a combinational read port, one write port and a synchronous reset of the valid bits. It is instantiated three times (TU, PS, SP).
- Top level holds the training/prediction logic, alloc_ptr and the output registers.

Test Plan:
1. Reset high for 2 cycles, then v_in=0 -> pf_valid=0 and pf_addr=0 every cycle.
2. Stream training, one access per cycle:
   - pc0/0x10 then pc0/0x11: PS[0x10]=0, PS[0x11]=1, alloc_ptr=16.
   - Then pc1/0x12 (TU install only), then pc0/0x13: PS[0x13]=2, SP[2]=0x13.
3. Prediction, continuing from (2):
   - pc2/0x11 -> next cycle pf_valid[0]=1, pf_addr=0x0013.
   - pc3/0x11 and pc4/0x11 give the same result on consecutive cycles.
4. Unseen address: pc5/0x40 -> pf_valid=0. Same address repeated from one PC (0x20, 0x20) -> no PS write.
5. Confidence:
   - Train 0x10->0x11 three more times (conf=3), then train 0x30->0x11.
   - PS[0x11] keeps str 1 with conf=2. Reassignment happens only after conf reaches 0 and one further conflicting training.
6. Chunk boundary and reset:
   - Train a chain of 16 addresses from one PC; the 17th address gets no PS entry.
   - Assert reset mid-stream -> the following access returns pf_valid=0.

Source files
------------

// File: rtl/isb_pkg.sv
// Shared types and constants for the ISB temporal prefetcher.
// Table entries are packed so that the lookup tag is always the most
// significant field. The generic table relies on that to locate the tag.
package isb_pkg;

    localparam int ADDR_W = 16;
    localparam int STR_W  = 16;
    localparam int CONF_W = 2;
    localparam logic [CONF_W-1:0] CONF_MAX = 2'd3;

    // Training unit: the last address seen for each PC.
    typedef struct packed {
        logic [15:0]       pc;
        logic [ADDR_W-1:0] last_addr;
    } tu_entry_t;

    // Physical-to-structural map, with a confidence counter.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STR_W-1:0]  str;
        logic [CONF_W-1:0] conf;
    } ps_entry_t;

    // Structural-to-physical map.
    typedef struct packed {
        logic [STR_W-1:0]  str;
        logic [ADDR_W-1:0] addr;
    } sp_entry_t;

endpackage

// File: rtl/isb_dm_table.sv
// Direct-mapped tagged table with N_RD combinational lookup ports and N_WR
// write ports.
// Each stored word is DATA_W bits wide. Its upper TAG_W bits are the tag, and
// the low IDX_W bits of the tag select the row.
// Ports:
//   clk, srst_i       clock and synchronous reset, which clears the valid bits
//   rd_key_i          lookup keys, one per read port
//   rd_hit_o          high when the row is valid and its tag matches the key
//   rd_data_o         the raw row contents (old data during a same-cycle write)
//   wr_en_i/wr_data_i write ports. On an index collision the higher port wins.
module isb_dm_table #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 16,
    parameter int DATA_W = 32,
    parameter int N_RD   = 1,
    parameter int N_WR   = 1
) (
    input  logic                          clk,
    input  logic                          srst_i,
    input  logic [N_RD-1:0][TAG_W-1:0]    rd_key_i,
    output logic [N_RD-1:0]               rd_hit_o,
    output logic [N_RD-1:0][DATA_W-1:0]   rd_data_o,
    input  logic [N_WR-1:0]               wr_en_i,
    input  logic [N_WR-1:0][DATA_W-1:0]   wr_data_i
);

    localparam int DEPTH   = 1 << IDX_W;
    localparam int TAG_LSB = DATA_W - TAG_W;

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [IDX_W-1:0] rd_idx;
            assign rd_idx        = rd_key_i[gi][IDX_W-1:0];
            assign rd_data_o[gi] = mem_q[rd_idx];
            assign rd_hit_o[gi]  = valid_q[rd_idx] &&
                                   (mem_q[rd_idx][DATA_W-1 -: TAG_W] == rd_key_i[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst_i) begin
            valid_q <= '0;
        end else begin
            for (int w = 0; w < N_WR; w++) begin
                if (wr_en_i[w]) begin
                    valid_q[wr_data_i[w][TAG_LSB +: IDX_W]] <= 1'b1;
                end
            end
        end
    end

    // Only the valid bits are reset. Stale payloads are harmless.
    always_ff @(posedge clk) begin
        if (!srst_i) begin
            for (int w = 0; w < N_WR; w++) begin
                if (wr_en_i[w]) begin
                    mem_q[wr_data_i[w][TAG_LSB +: IDX_W]] <= wr_data_i[w];
                end
            end
        end
    end

endmodule

// File: rtl/isb_prefetcher.sv
// Irregular Stream Buffer temporal prefetcher.
// It trains per-PC address correlations into a linear structural space. For
// each access it predicts the next DEGREE structural successors, registered
// one cycle later.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   v_in, pc_in, addr_in  one observed access per cycle
//   pf_valid[k]        slot k of pf_addr carries a prefetch candidate
//   pf_addr            slot k at bits [16k+15:16k]
module isb_prefetcher
    import isb_pkg::*;
#(
    parameter int DEGREE     = 1,
    parameter int TU_ENTRIES = 16,
    parameter int PS_ENTRIES = 64,
    parameter int SP_ENTRIES = 64,
    parameter int CHUNK      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   v_in,
    input  logic [15:0]            pc_in,
    input  logic [15:0]            addr_in,
    output logic [DEGREE-1:0]      pf_valid,
    output logic [16*DEGREE-1:0]   pf_addr
);

    localparam int TU_W = $bits(tu_entry_t);
    localparam int PS_W = $bits(ps_entry_t);
    localparam int SP_W = $bits(sp_entry_t);
    localparam logic [STR_W-1:0] CHUNK_MASK = STR_W'(CHUNK - 1);

    // Training unit: one read port, one write port
    logic [0:0][15:0]     tu_rd_key;
    logic [0:0]           tu_hit;
    logic [0:0][TU_W-1:0] tu_rd_data;
    logic [0:0]           tu_wr_en;
    logic [0:0][TU_W-1:0] tu_wr_data;
    tu_entry_t            tu_rd;

    // PS map. Read port 0 looks up B (current address) and port 1 looks up A
    // (previous address). Write port 0 installs A and port 1 updates B, so B
    // wins an index collision.
    logic [1:0][ADDR_W-1:0] ps_rd_key;
    logic [1:0]             ps_hit;
    logic [1:0][PS_W-1:0]   ps_rd_data;
    logic [1:0]             ps_wr_en;
    ps_entry_t              ps_b, ps_a, ps_new_a, ps_new_b;

    // SP map. DEGREE prediction reads, and writes for SP[s_A] and SP[t].
    logic [DEGREE-1:0][STR_W-1:0] sp_rd_key;
    logic [DEGREE-1:0]            sp_hit;
    logic [DEGREE-1:0][SP_W-1:0]  sp_rd_data;
    logic [1:0]                   sp_wr_en;
    sp_entry_t                    sp_new_a, sp_new_b;

    logic [STR_W-1:0]      alloc_q, alloc_d;
    logic [STR_W-1:0]      s_a, t_str;
    logic [ADDR_W-1:0]     last_a;
    logic                  train;
    logic [DEGREE-1:0]     pf_valid_q, pf_valid_d;
    logic [16*DEGREE-1:0]  pf_addr_q, pf_addr_d;

    assign tu_rd        = tu_rd_data[0];
    assign ps_b         = ps_rd_data[0];
    assign ps_a         = ps_rd_data[1];
    assign last_a       = tu_rd.last_addr;
    assign tu_rd_key[0] = pc_in;
    assign ps_rd_key    = {last_a, addr_in};
    assign tu_wr_en[0]  = v_in;
    assign tu_wr_data[0] = {pc_in, addr_in};
    assign train        = v_in && tu_hit[0] && (last_a != addr_in);

    // A structural id is either the existing mapping of A or a fresh chunk.
    assign s_a      = ps_hit[1] ? ps_a.str : alloc_q;
    assign t_str    = s_a + STR_W'(1);
    assign ps_new_a = '{addr: last_a, str: alloc_q, conf: '0};
    assign sp_new_a = '{str: alloc_q, addr: last_a};
    assign sp_new_b = '{str: t_str, addr: addr_in};

    always_comb begin
        ps_wr_en = '0;
        sp_wr_en = '0;
        alloc_d  = alloc_q;
        ps_new_b = '{addr: addr_in, str: t_str, conf: '0};
        if (train) begin
            if (!ps_hit[1]) begin
                ps_wr_en[0] = 1'b1;
                sp_wr_en[0] = 1'b1;
                alloc_d     = alloc_q + STR_W'(CHUNK);
            end
            // The last slot of a chunk has no successor inside the chunk.
            if ((s_a & CHUNK_MASK) != CHUNK_MASK) begin
                ps_wr_en[1] = 1'b1;
                if (!ps_hit[0]) begin
                    sp_wr_en[1] = 1'b1;
                end else if (ps_b.str == t_str) begin
                    ps_new_b = ps_b;
                    if (ps_b.conf != CONF_MAX) ps_new_b.conf = ps_b.conf + CONF_W'(1);
                end else if (ps_b.conf != '0) begin
                    // A confident mapping only loses confidence and is not moved.
                    ps_new_b      = ps_b;
                    ps_new_b.conf = ps_b.conf - CONF_W'(1);
                end else begin
                    sp_wr_en[1] = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEGREE; gi++) begin : g_pred
            sp_entry_t sp_e;
            logic      unused_sp_str;
            assign sp_e           = sp_rd_data[gi];
            assign unused_sp_str  = ^sp_e.str;
            assign sp_rd_key[gi]  = ps_b.str + STR_W'(gi + 1);
            assign pf_valid_d[gi] = v_in && ps_hit[0] && sp_hit[gi];
            assign pf_addr_d[gi*16 +: 16] = pf_valid_d[gi] ? sp_e.addr : 16'h0000;
        end
    endgenerate

    logic unused_fields;
    assign unused_fields = ^{tu_rd.pc, ps_a.addr, ps_a.conf};

    isb_dm_table #(.IDX_W($clog2(TU_ENTRIES)), .TAG_W(16), .DATA_W(TU_W),
                   .N_RD(1), .N_WR(1)) u_tu (
        .clk(clk), .srst_i(reset),
        .rd_key_i(tu_rd_key), .rd_hit_o(tu_hit), .rd_data_o(tu_rd_data),
        .wr_en_i(tu_wr_en), .wr_data_i(tu_wr_data)
    );

    isb_dm_table #(.IDX_W($clog2(PS_ENTRIES)), .TAG_W(ADDR_W), .DATA_W(PS_W),
                   .N_RD(2), .N_WR(2)) u_ps (
        .clk(clk), .srst_i(reset),
        .rd_key_i(ps_rd_key), .rd_hit_o(ps_hit), .rd_data_o(ps_rd_data),
        .wr_en_i(ps_wr_en), .wr_data_i({ps_new_b, ps_new_a})
    );

    isb_dm_table #(.IDX_W($clog2(SP_ENTRIES)), .TAG_W(STR_W), .DATA_W(SP_W),
                   .N_RD(DEGREE), .N_WR(2)) u_sp (
        .clk(clk), .srst_i(reset),
        .rd_key_i(sp_rd_key), .rd_hit_o(sp_hit), .rd_data_o(sp_rd_data),
        .wr_en_i(sp_wr_en), .wr_data_i({sp_new_b, sp_new_a})
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_q    <= '0;
            pf_valid_q <= '0;
            pf_addr_q  <= '0;
        end else begin
            alloc_q    <= alloc_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
        end
    end

    assign pf_valid = pf_valid_q;
    assign pf_addr  = pf_addr_q;

endmodule

// File: tb/tb_isb_prefetcher.sv
// Directed testbench for isb_prefetcher with DEGREE=1.
module tb_isb_prefetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_in;
    logic [15:0] pc_in;
    logic [15:0] addr_in;
    logic [0:0]  pf_valid;
    logic [15:0] pf_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int q_n      = 0;

    isb_prefetcher #(.DEGREE(1)) dut (
        .clk(clk), .reset(reset), .v_in(v_in), .pc_in(pc_in),
        .addr_in(addr_in), .pf_valid(pf_valid), .pf_addr(pf_addr)
    );

    always #5 clk = ~clk;

    // PC n maps to training-unit index n.
    function automatic logic [15:0] pcn(input int n);
        return 16'h0A00 + 16'(n);
    endfunction

    // Apply one access. Return 1 time unit after the edge, when the registered
    // prediction for that access is visible.
    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] a);
        @(negedge clk);
        v_in = v; pc_in = pc; addr_in = a;
        @(posedge clk);
        #1;
        $display("access v=%b pc=%h addr=%h -> pf_valid=%b pf_addr=%h",
                 v, pc, a, pf_valid, pf_addr);
    endtask

    // Probe from TU index 6 with a new tag each time. The probe always misses
    // the training unit, so it never trains a correlation.
    task automatic query(input logic [15:0] a);
        drive(1'b1, 16'h8006 + 16'(q_n * 16), a);
        q_n++;
    endtask

    task automatic test_reset;
        reset = 1'b1; v_in = 1'b0; pc_in = '0; addr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (pf_valid !== 1'b0 || pf_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b addr=%h, want 0/0000", pf_valid, pf_addr);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 16'h0000);
            n_checks++;
            if (pf_valid !== 1'b0 || pf_addr !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_idle%0d: valid=%b addr=%h, want 0/0000", i, pf_valid, pf_addr);
            end
        end
    endtask

    task automatic test_train;
        logic [15:0] pcs [4];
        logic [15:0] adr [4];
        pcs = '{pcn(0), pcn(0), pcn(1), pcn(0)};
        adr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        // None of these addresses is in PS before its own write.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pcs[i], adr[i]);
            n_checks++;
            if (pf_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL train_step%0d: valid=%b, want 0", i, pf_valid);
            end
        end
    endtask

    task automatic test_predict;
        logic [15:0] pcs [3];
        pcs = '{pcn(2), pcn(3), pcn(4)};
        // PS[0x11]=1 and SP[2]=0x13.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], 16'h0011);
            n_checks++;
            if (pf_valid !== 1'b1 || pf_addr !== 16'h0013) begin
                n_fail++;
                $display("FAIL predict_0x11_pc%0d: valid=%b addr=%h, want 1/0013", i + 2, pf_valid, pf_addr);
            end
        end
        drive(1'b0, 16'h0000, 16'h0011);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL predict_idle: valid=%b, want 0", pf_valid);
        end
        // PS[0x10]=0 and SP[1]=0x11.
        query(16'h0010);
        n_checks++;
        if (pf_valid !== 1'b1 || pf_addr !== 16'h0011) begin
            n_fail++;
            $display("FAIL predict_0x10: valid=%b addr=%h, want 1/0011", pf_valid, pf_addr);
        end
        // PS[0x13]=2 and SP[3] is empty.
        query(16'h0013);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL predict_0x13_tail: valid=%b, want 0", pf_valid);
        end
    endtask

    task automatic test_unseen;
        drive(1'b1, pcn(5), 16'h0040);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unseen_0x40: valid=%b, want 0", pf_valid);
        end
        drive(1'b1, pcn(7), 16'h0020);
        drive(1'b1, pcn(7), 16'h0020);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_0x20: valid=%b, want 0", pf_valid);
        end
        query(16'h0020);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_no_ps: valid=%b, want 0", pf_valid);
        end
    endtask

    task automatic test_confidence;
        // Train 0x10->0x11 from three new PCs. Confidence goes 0->1->2->3.
        for (int i = 9; i <= 11; i++) begin
            drive(1'b1, pcn(i), 16'h0010);
            n_checks++;
            if (pf_valid !== 1'b1 || pf_addr !== 16'h0011) begin
                n_fail++;
                $display("FAIL conf_pred10_pc%0d: valid=%b addr=%h, want 1/0011", i, pf_valid, pf_addr);
            end
            drive(1'b1, pcn(i), 16'h0011);
            n_checks++;
            if (pf_valid !== 1'b1 || pf_addr !== 16'h0013) begin
                n_fail++;
                $display("FAIL conf_pred11_pc%0d: valid=%b addr=%h, want 1/0013", i, pf_valid, pf_addr);
            end
        end
        // Three conflicting 0x30->0x11 trainings take confidence from 3 to 0.
        // 0x30 gets str 16, and PS[0x11] keeps str 1 throughout.
        for (int i = 12; i <= 14; i++) begin
            drive(1'b1, pcn(i), 16'h0030);
            drive(1'b1, pcn(i), 16'h0011);
            query(16'h0011);
            n_checks++;
            if (pf_valid !== 1'b1 || pf_addr !== 16'h0013) begin
                n_fail++;
                $display("FAIL conf_keep_pc%0d: valid=%b addr=%h, want 1/0013", i, pf_valid, pf_addr);
            end
        end
        // The next conflicting training, with confidence at 0, moves 0x11 to
        // str 17.
        drive(1'b1, pcn(15), 16'h0030);
        drive(1'b1, pcn(15), 16'h0011);
        query(16'h0011);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL conf_reassign_0x11: valid=%b, want 0", pf_valid);
        end
        query(16'h0030);
        n_checks++;
        if (pf_valid !== 1'b1 || pf_addr !== 16'h0011) begin
            n_fail++;
            $display("FAIL conf_reassign_0x30: valid=%b addr=%h, want 1/0011", pf_valid, pf_addr);
        end
    endtask

    task automatic test_chunk;
        // A new chunk starts at str 32, so 0x100+i maps to 32+i. 0x110 would
        // need str 48, which lies past the chunk.
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, 16'h4001, 16'h0100 + 16'(i));
            n_checks++;
            if (pf_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL chunk_train%0d: valid=%b, want 0", i, pf_valid);
            end
        end
        query(16'h0105);
        n_checks++;
        if (pf_valid !== 1'b1 || pf_addr !== 16'h0106) begin
            n_fail++;
            $display("FAIL chunk_0x105: valid=%b addr=%h, want 1/0106", pf_valid, pf_addr);
        end
        query(16'h010E);
        n_checks++;
        if (pf_valid !== 1'b1 || pf_addr !== 16'h010F) begin
            n_fail++;
            $display("FAIL chunk_0x10E: valid=%b addr=%h, want 1/010F", pf_valid, pf_addr);
        end
        query(16'h010F);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk_last_slot: valid=%b, want 0", pf_valid);
        end
        query(16'h0110);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk_17th: valid=%b, want 0", pf_valid);
        end
    endtask

    task automatic test_reset_mid;
        // Without the reset, this access would predict 0x106.
        @(negedge clk);
        reset = 1'b1; v_in = 1'b1; pc_in = 16'h8006 + 16'(q_n * 16); addr_in = 16'h0105;
        q_n++;
        @(posedge clk);
        #1;
        $display("access reset=1 addr=0105 -> pf_valid=%b pf_addr=%h", pf_valid, pf_addr);
        n_checks++;
        if (pf_valid !== 1'b0 || pf_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b addr=%h, want 0/0000", pf_valid, pf_addr);
        end
        @(negedge clk); reset = 1'b0;
        query(16'h0105);
        n_checks++;
        if (pf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cleared: valid=%b, want 0", pf_valid);
        end
        // After reset, alloc_ptr is 0 again: 0x50 gets str 0 and 0x51 gets str 1.
        drive(1'b1, pcn(3), 16'h0050);
        drive(1'b1, pcn(3), 16'h0051);
        query(16'h0050);
        n_checks++;
        if (pf_valid !== 1'b1 || pf_addr !== 16'h0051) begin
            n_fail++;
            $display("FAIL reset_retrain: valid=%b addr=%h, want 1/0051", pf_valid, pf_addr);
        end
        drive(1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_train();
        test_predict();
        test_unseen();
        test_confidence();
        test_chunk();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
